// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: access sizes, response
// states and the per-grant response payload.
package mem_port_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_RSV = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_F = 2'd1,
        RESP_D = 2'd2
    } resp_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] word;
        logic              err;
        size_e             size;
        logic              is_unsigned;
    } resp_t;

    // Misaligned halves/words and the reserved size are rejected.
    function automatic logic access_bad(size_e size, logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [MASK_W-1:0] size_mask(size_e size);
        logic [MASK_W-1:0] mask;
        mask = '0;
        case (size)
            SZ_B:    mask = 4'b0001;
            SZ_H:    mask = 4'b0011;
            SZ_W:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave is the arbiter view,
// master is the requester/memory environment view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    import mem_port_arbiter_pkg::*;

    logic                  f_req;
    logic [ADDR_WIDTH-1:0] f_addr;
    logic                  f_gnt;
    logic                  f_rvalid;
    logic [DATA_W-1:0]     f_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [1:0]            d_size;
    logic                  d_unsigned;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_err;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [MASK_W-1:0]     mem_wmask;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               mem_addr, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/mem_port_arbiter_load_extend.sv
// Right-aligned load data extension: byte/half are sign- or zero-extended,
// word passes through.
module load_extend
    import mem_port_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  size_e             size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] ext_c
);

    always_comb begin
        ext_c = word;
        case (size)
            SZ_B:    ext_c = {{(DATA_W-8){~is_unsigned & word[7]}}, word[7:0]};
            SZ_H:    ext_c = {{(DATA_W-16){~is_unsigned & word[15]}}, word[15:0]};
            default: ext_c = word;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one combinational-read memory port between a
// fetch requester and a load/store requester, with one-cycle registered responses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    resp_state_e           state_q, state_d;
    resp_t                 resp_q, resp_d;
    logic                  last_was_d_q, last_was_d_d;
    logic                  f_win, d_win, d_bad;
    size_e                 d_size_e;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [DATA_W-1:0]     d_ext;

    assign d_size_e = size_e'(bus.d_size);
    assign d_bad    = access_bad(d_size_e, bus.d_addr[1:0]);

    // Fetch wins a contest unless it was the most recent grant; nothing while in reset.
    assign f_win = reset & bus.f_req & (~bus.d_req | last_was_d_q);
    assign d_win = reset & bus.d_req & ~f_win;

    assign bus.f_gnt = f_win;
    assign bus.d_gnt = d_win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            resp_q       <= '0;
            last_was_d_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            resp_q       <= resp_d;
            last_was_d_q <= last_was_d_d;
        end
    end

    // Next response state, captured response and memory-port drive for the winner.
    always_comb begin
        state_d       = IDLE;
        resp_d        = '0;
        last_was_d_d  = last_was_d_q;
        addr_sel      = '0;
        bus.mem_wdata = '0;
        bus.mem_wmask = '0;
        if (f_win) begin
            state_d      = RESP_F;
            last_was_d_d = 1'b0;
            addr_sel     = bus.f_addr;
            resp_d.word  = bus.mem_rdata;
        end else if (d_win) begin
            state_d            = RESP_D;
            last_was_d_d       = 1'b1;
            addr_sel           = bus.d_addr;
            bus.mem_wdata      = bus.d_wdata;
            resp_d.err         = d_bad;
            resp_d.size        = d_size_e;
            resp_d.is_unsigned = bus.d_unsigned;
            if (!d_bad) begin
                if (bus.d_we) begin
                    bus.mem_wmask = size_mask(d_size_e);
                end else begin
                    resp_d.word = bus.mem_rdata;
                end
            end
        end
        bus.mem_addr = addr_sel;
    end

    load_extend u_load_extend (
        .word        (resp_q.word),
        .size        (resp_q.size),
        .is_unsigned (resp_q.is_unsigned),
        .ext_c       (d_ext)
    );

    // Stores and errored accesses capture a zero word, so d_rdata reads 0 for them.
    assign bus.f_rvalid = (state_q == RESP_F);
    assign bus.d_rvalid = (state_q == RESP_D);
    assign bus.f_rdata  = bus.f_rvalid ? resp_q.word : '0;
    assign bus.d_rdata  = bus.d_rvalid ? d_ext : '0;
    assign bus.d_err    = bus.d_rvalid & resp_q.err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a byte-array
// reference memory and a plain round-robin/response model.
module tb_mem_port_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(32)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Environment memory, 256 bytes, combinational read.
    logic [7:0] mem [256];
    logic       poke_en   = 1'b0;
    logic [7:0] poke_addr = 8'h00;
    logic [7:0] poke_data = 8'h00;

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else for (int i = 0; i < 4; i++)
            if (bus.mem_wmask[i]) mem[bus.mem_addr[7:0] + 8'(i)] <= bus.mem_wdata[8*i +: 8];
    end

    always_comb
        for (int i = 0; i < 4; i++) bus.mem_rdata[8*i +: 8] = mem[bus.mem_addr[7:0] + 8'(i)];

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    byte unsigned ref_mem [256];
    bit           m_last_d;
    bit           e_fv, e_dv, e_derr;
    logic [31:0]  e_fdata, e_ddata;
    bit           last_fw, last_dw;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(int unsigned a, int unsigned nbytes, bit sext);
        longint v = 0;
        for (int i = 0; i < int'(nbytes); i++) v += longint'(ref_mem[(a + i) % 256]) << (8 * i);
        if (sext && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
            v -= longint'(1) << (8 * nbytes);
        return 32'(v);
    endfunction

    task automatic model_reset();
        m_last_d = 1'b1;
        e_fv = 0; e_dv = 0; e_derr = 0;
        e_fdata = '0; e_ddata = '0;
        last_fw = 0; last_dw = 0;
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic step();
        bit fw, dw, bad, st;
        int unsigned sz, a, nb;
        logic [3:0] em;
        logic [31:0] ea;
        #1;
        chk("f_rvalid", 32'(bus.f_rvalid), 32'(e_fv));
        chk("f_rdata",  bus.f_rdata, e_fdata);
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(e_dv));
        chk("d_rdata",  bus.d_rdata, e_ddata);
        chk("d_err",    32'(bus.d_err), 32'(e_derr));

        fw  = bus.f_req && (!bus.d_req || m_last_d);
        dw  = bus.d_req && !fw;
        sz  = 32'(bus.d_size);
        a   = bus.d_addr;
        nb  = 32'(1) << sz;
        bad = (sz == 3) || (a % nb != 0);
        st  = dw && bus.d_we && !bad;
        em  = st ? 4'((1 << nb) - 1) : 4'b0000;
        ea  = fw ? bus.f_addr : (dw ? bus.d_addr : 32'h0);

        chk("f_gnt",     32'(bus.f_gnt), 32'(fw));
        chk("d_gnt",     32'(bus.d_gnt), 32'(dw));
        chk("mem_wmask", 32'(bus.mem_wmask), 32'(em));
        chk("mem_addr",  bus.mem_addr, ea);
        if (st || (!fw && !dw)) chk("mem_wdata", bus.mem_wdata, st ? bus.d_wdata : 32'h0);

        e_fv    = fw;
        e_fdata = fw ? ref_read(bus.f_addr, 4, 1'b0) : 32'h0;
        e_dv    = dw;
        e_derr  = dw && bad;
        e_ddata = (dw && !bad && !bus.d_we) ? ref_read(a, nb, !bus.d_unsigned) : 32'h0;
        if (st) for (int i = 0; i < int'(nb); i++) ref_mem[(a + i) % 256] = bus.d_wdata[8*i +: 8];
        if (fw) m_last_d = 1'b0;
        else if (dw) m_last_d = 1'b1;
        last_fw = fw;
        last_dw = dw;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_f(input bit req, input logic [31:0] addr);
        bus.f_req  = req;
        bus.f_addr = addr;
    endtask

    task automatic drive_d(input bit req, input bit we, input logic [1:0] size, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bus.d_req      = req;
        bus.d_we       = we;
        bus.d_size     = size;
        bus.d_unsigned = uns;
        bus.d_addr     = addr;
        bus.d_wdata    = wdata;
    endtask

    task automatic poke(input int unsigned a, input byte unsigned v);
        poke_en   = 1'b1;
        poke_addr = 8'(a);
        poke_data = v;
        ref_mem[a % 256] = v;
        @(posedge clk);
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    initial begin
        drive_f(1'b0, 32'h0);
        drive_d(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        model_reset();
        @(negedge clk);

        // Fill memory while held in reset, with both requests up to check suppression.
        drive_f(1'b1, 32'h10);
        drive_d(1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 32'h12345678);
        for (int i = 0; i < 256; i++) poke(i, 8'($urandom_range(0, 255)));
        poke(32'h10, 8'hEF); poke(32'h11, 8'hBE); poke(32'h12, 8'hAD); poke(32'h13, 8'hDE);
        poke(32'h20, 8'h80);
        #1;
        chk("rst_f_gnt",    32'(bus.f_gnt), 32'h0);
        chk("rst_d_gnt",    32'(bus.d_gnt), 32'h0);
        chk("rst_wmask",    32'(bus.mem_wmask), 32'h0);
        chk("rst_f_rvalid", 32'(bus.f_rvalid), 32'h0);
        chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'h0);
        chk("rst_d_err",    32'(bus.d_err), 32'h0);
        @(negedge clk);
        drive_f(1'b0, 32'h0);
        drive_d(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        model_reset();

        // Lone fetch of a known word.
        drive_f(1'b1, 32'h10); step();
        drive_f(1'b0, 32'h0);  step();
        // step() already compared the response; this pins the literal value too.
        // (sampled one cycle late would be 0, so check via model only above)

        // Byte store, misaligned word store, then fetch the surrounding word.
        drive_d(1'b1, 1'b1, 2'd0, 1'b0, 32'h5, 32'h000000AB); step();
        drive_d(1'b1, 1'b1, 2'd2, 1'b0, 32'h6, 32'hCAFEF00D); step();
        drive_d(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        drive_f(1'b1, 32'h4); step();
        drive_f(1'b0, 32'h0);
        chk("byte1_after_store", 32'(bus.f_rdata[15:8]), 32'hAB);
        step();

        // Signed and unsigned byte loads of 0x80.
        drive_d(1'b1, 1'b0, 2'd0, 1'b0, 32'h20, 32'h0); step();
        chk("ld_b_signed", bus.d_rdata, 32'hFFFFFF80);
        drive_d(1'b1, 1'b0, 2'd0, 1'b1, 32'h20, 32'h0); step();
        chk("ld_b_unsigned", bus.d_rdata, 32'h00000080);
        drive_d(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0); step();

        // Contested requests alternate.
        drive_f(1'b1, 32'h10);
        drive_d(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 4; i++) step();
        drive_f(1'b0, 32'h0);
        drive_d(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        step();

        // Reset during a fetch grant drops the response and restores fetch priority.
        drive_f(1'b1, 32'h10); #1;
        chk("pre_rst_f_gnt", 32'(bus.f_gnt), 32'h1);
        reset = 1'b0; #1;
        chk("in_rst_f_gnt", 32'(bus.f_gnt), 32'h0);
        chk("in_rst_wmask", 32'(bus.mem_wmask), 32'h0);
        model_reset();
        @(posedge clk); @(negedge clk); #1;
        chk("dropped_f_rvalid", 32'(bus.f_rvalid), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        drive_d(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        step();
        drive_f(1'b0, 32'h0);
        drive_d(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        step();

        // Random traffic; a pending (ungranted) request is held stable.
        for (int n = 0; n < 3000; n++) begin
            if (!(bus.f_req && !last_fw))
                drive_f($urandom_range(0, 3) != 0, 32'($urandom_range(0, 63)) * 4);
            if (!(bus.d_req && !last_dw))
                drive_d($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        32'($urandom_range(0, 251)), $urandom);
            step();
        end
        drive_f(1'b0, 32'h0);
        drive_d(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
